// File: rtl/mio_responder.sv
// Memory-mapped I/O responder: 256x32 RAM, LED register, synchronized switches and a cycle counter.
// Optional `MIO_ERR_EN: flag unmapped/misaligned accesses on bus_err and suppress their effects.
module mio_responder #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CPU_MIO,
  input  logic        MemRW,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_out,
  input  logic [15:0] SW,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic [15:0] LED,
  output logic        bus_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        rw_q;
  logic        ready_q;
  logic [15:0] led_q;
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] sw_meta_q, sw_sync_q;
  logic [31:0] rd_data_q;
  logic        rd_ram_q;
  logic [31:0] ram_rd_q;
  logic [31:0] mem [0:255];

  logic        in_idle, fire;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_rw;
  logic        sel_ram, sel_led, sel_sw, sel_cyc, acc_err;
  logic        wr_ok, rd_ok, ram_we, ram_re;
  logic [31:0] io_rdata;

  // With zero wait states the access uses the live request; otherwise the latched copy.
  assign in_idle   = (state_q == ST_IDLE);
  assign acc_addr  = in_idle ? Addr_in  : addr_q;
  assign acc_wdata = in_idle ? Data_out : wdata_q;
  assign acc_rw    = in_idle ? MemRW    : rw_q;
  assign fire = rst_n & ((in_idle & CPU_MIO & (WAIT_CYCLES == 0)) |
                         ((state_q == ST_WAIT) & (wcnt_q == 4'd0)));

  assign sel_ram = (acc_addr[31:10] == 22'd0);
  assign sel_led = (acc_addr[31:2] == 30'h3C00_0000);
  assign sel_sw  = (acc_addr[31:2] == 30'h3C00_0001);
  assign sel_cyc = (acc_addr[31:2] == 30'h3C00_0002);

`ifdef MIO_ERR_EN
  logic err_q;
  assign acc_err = (acc_addr[1:0] != 2'b00) | ~(sel_ram | sel_led | sel_sw | sel_cyc);
  assign bus_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= fire & acc_err;
    end
  end
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^acc_addr[1:0];
  assign acc_err = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign wr_ok  = fire & acc_rw & ~acc_err;
  assign rd_ok  = fire & ~acc_rw;
  assign ram_we = wr_ok & sel_ram;
  assign ram_re = rd_ok & sel_ram & ~acc_err;
  assign cyc_d  = (wr_ok & sel_cyc) ? 32'd0 : cyc_q + 32'd1;

  always_comb begin
    io_rdata = 32'd0;
    if (!acc_err) begin
      if (sel_led)      io_rdata = {16'd0, led_q};
      else if (sel_sw)  io_rdata = {16'd0, sw_sync_q};
      else if (sel_cyc) io_rdata = cyc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (CPU_MIO) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) state_d = ST_ACK;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rw_q      <= 1'b0;
      ready_q   <= 1'b0;
      led_q     <= 16'd0;
      cyc_q     <= 32'd0;
      sw_meta_q <= 16'd0;
      sw_sync_q <= 16'd0;
      rd_data_q <= 32'd0;
      rd_ram_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      ready_q   <= fire;
      cyc_q     <= cyc_d;
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      if (in_idle && CPU_MIO) begin
        addr_q  <= Addr_in;
        wdata_q <= Data_out;
        rw_q    <= MemRW;
      end
      if (wr_ok && sel_led) led_q <= acc_wdata[15:0];
      if (rd_ok) begin
        rd_data_q <= io_rdata;
        rd_ram_q  <= sel_ram & ~acc_err;
      end
    end
  end

  // RAM has no reset so it maps onto block RAM; read data is registered on the access edge.
  always_ff @(posedge clk) begin
    if (ram_we) mem[acc_addr[9:2]] <= acc_wdata;
    if (ram_re) ram_rd_q <= mem[acc_addr[9:2]];
  end

  assign Data_in   = rd_ram_q ? ram_rd_q : rd_data_q;
  assign MIO_ready = ready_q;
  assign LED       = led_q;

endmodule
